// File: rtl/mem_stage_controller.sv
// -----------------------------------------------------------------------------
// mem_stage_controller
//
// Sequences the MEM stage of the pipeline. It accepts an op from the EX/MEM
// register, runs the data-memory request/response handshake, and holds the
// upstream stages while a load or store is outstanding. It also tells the
// MEM/WB buffer whether to capture a real result or a bubble.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, a watchdog aborts a transaction that spends TIMEOUT_CYCLES
//   cycles in REQ+WAIT. In that case it zeroes wb_load_data and pulses
//   mem_error. When undefined, the FSM waits indefinitely and mem_error is
//   tied low.
//
// Ports
//   clock, reset           rising-edge clock, asynchronous active-low reset
//   op_valid               EX/MEM holds a valid instruction
//   memRead_in/memWrite_in op is a load / store (a load wins if both are set)
//   addr_in, store_data_in effective address and store data
//   mem_req_read/write     request strobes to data memory
//   mem_req_addr/data      address and store data latched for the request
//   mem_ready              memory accepts the request this cycle
//   mem_valid              load data valid this cycle
//   mem_load_data          load data from memory
//   stall                  hold PC/IF/ID/EX/EX-MEM registers
//   buf_enable             MEM/WB buffer captures this cycle
//   buf_bubble             MEM/WB buffer captures a NOP
//   wb_load_data           registered load result for the MEM/WB buffer
//   mem_error              one-cycle pulse on watchdog timeout
// -----------------------------------------------------------------------------
module mem_stage_controller #(
    parameter int CORE           = 0,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_BITS   = 20,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    op_valid,
    input  logic                    memRead_in,
    input  logic                    memWrite_in,
    input  logic [ADDRESS_BITS-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0]   store_data_in,
    output logic                    mem_req_read,
    output logic                    mem_req_write,
    output logic [ADDRESS_BITS-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_data,
    input  logic                    mem_ready,
    input  logic                    mem_valid,
    input  logic [DATA_WIDTH-1:0]   mem_load_data,
    output logic                    stall,
    output logic                    buf_enable,
    output logic                    buf_bubble,
    output logic [DATA_WIDTH-1:0]   wb_load_data,
    output logic                    mem_error
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic                    is_load_r;
    logic [ADDRESS_BITS-1:0] addr_r;
    logic [DATA_WIDTH-1:0]   data_r;
    logic [DATA_WIDTH-1:0]   wb_data_r;

    logic mem_op_s;
    logic latch_s;
    logic capture_s;
    logic timeout_s;
    logic timeout_hit_s;
    logic stall_s;
    logic bubble_s;
    logic req_read_s;
    logic req_write_s;

    assign mem_op_s = op_valid & (memRead_in | memWrite_in);

`ifdef MEM_TIMEOUT_EN
    logic [15:0] tmo_cnt_r;
    logic        mem_error_r;

    // Watchdog counter: cleared on entry to REQ, counts every REQ/WAIT cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt_r <= 16'd0;
        end else if (latch_s) begin
            tmo_cnt_r <= 16'd0;
        end else if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // A load accepted on the limit cycle enters WAIT with the count already
    // at the limit, so >= makes it expire on the next idle WAIT cycle.
    assign timeout_hit_s = (tmo_cnt_r >= 16'(TIMEOUT_CYCLES - 1));

    // Error pulse register: high for the single DONE cycle after a timeout.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_error_r <= 1'b0;
        end else begin
            mem_error_r <= timeout_s;
        end
    end

    assign mem_error = mem_error_r;
`else
    assign timeout_hit_s = 1'b0;
    assign mem_error     = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-state control decode.
    always_comb begin
        state_s     = state_r;
        latch_s     = 1'b0;
        capture_s   = 1'b0;
        timeout_s   = 1'b0;
        stall_s     = 1'b0;
        bubble_s    = 1'b1;
        req_read_s  = 1'b0;
        req_write_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mem_op_s) begin
                    latch_s = 1'b1;
                    stall_s = 1'b1;
                    state_s = ST_REQ;
                end else begin
                    bubble_s = ~op_valid;
                end
            end
            ST_REQ: begin
                stall_s     = 1'b1;
                req_read_s  = is_load_r;
                req_write_s = ~is_load_r;
                if (mem_ready) begin
                    if (is_load_r) begin
                        if (mem_valid) begin
                            capture_s = 1'b1;
                            state_s   = ST_DONE;
                        end else begin
                            state_s = ST_WAIT;
                        end
                    end else begin
                        state_s = ST_DONE;
                    end
                end else if (timeout_hit_s) begin
                    timeout_s = 1'b1;
                    state_s   = ST_DONE;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                stall_s = 1'b1;
                if (mem_valid) begin
                    capture_s = 1'b1;
                    state_s   = ST_DONE;
                end else if (timeout_hit_s) begin
                    timeout_s = 1'b1;
                    state_s   = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                bubble_s = 1'b0;
                state_s  = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Request latch and load-result register. A read wins over a write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            is_load_r <= 1'b0;
            addr_r    <= '0;
            data_r    <= '0;
            wb_data_r <= '0;
        end else begin
            if (latch_s) begin
                is_load_r <= memRead_in;
                addr_r    <= addr_in;
                data_r    <= store_data_in;
            end else begin
                is_load_r <= is_load_r;
                addr_r    <= addr_r;
                data_r    <= data_r;
            end
            if (capture_s) begin
                wb_data_r <= mem_load_data;
            end else if (timeout_s) begin
                wb_data_r <= '0;
            end else begin
                wb_data_r <= wb_data_r;
            end
        end
    end

    // While reset is held, the IDLE decode still sees live op inputs, so
    // stall and bubble are forced to their reset values here.
    assign stall         = reset & stall_s;
    assign buf_bubble    = (~reset) | bubble_s;
    assign buf_enable    = 1'b1;
    assign mem_req_read  = req_read_s;
    assign mem_req_write = req_write_s;
    assign mem_req_addr  = addr_r;
    assign mem_req_data  = data_r;
    assign wb_load_data  = wb_data_r;

endmodule

// File: tb/tb_mem_stage_controller.sv
module tb_mem_stage_controller;

    localparam int DW = 32;
    localparam int AW = 20;

    logic          clock;
    logic          reset;
    logic          op_valid, memRead_in, memWrite_in;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] store_data_in;
    logic          mem_req_read, mem_req_write;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data;
    logic          mem_ready, mem_valid;
    logic [DW-1:0] mem_load_data;
    logic          stall, buf_enable, buf_bubble, mem_error;
    logic [DW-1:0] wb_load_data;

    mem_stage_controller #(
        .CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock), .reset(reset),
        .op_valid(op_valid), .memRead_in(memRead_in), .memWrite_in(memWrite_in),
        .addr_in(addr_in), .store_data_in(store_data_in),
        .mem_req_read(mem_req_read), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_load_data(mem_load_data),
        .stall(stall), .buf_enable(buf_enable), .buf_bubble(buf_bubble),
        .wb_load_data(wb_load_data), .mem_error(mem_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    // Scoreboard queues filled by the stimulus, drained by the monitor.
    int            stall_q[$];
    logic [DW-1:0] res_q[$];
    req_t          req_q[$];

    int            n_checks = 0;
    int            n_fail   = 0;
    bit            mon_en   = 1'b0;
    int            stall_run = 0;
    logic [DW-1:0] last_load = '0;   // model of wb_load_data

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT output with no expected entry", name);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd32();
        logic [DW-1:0] v;
        v = $urandom;
        return v;
    endfunction

    // Monitor: compares DUT outputs against scoreboard entries.
    req_t mrq;
    always @(negedge clock) begin
        if (mon_en) begin
            chk("buf_enable", buf_enable, 1);
            chk("mem_error_idle", mem_error, 0);
            if (stall) begin
                chk("bubble_while_stalled", buf_bubble, 1);
                stall_run++;
            end else if (stall_run != 0) begin
                if (stall_q.size() == 0) flag("stall_run");
                else chk("stall_cycles", stall_run, stall_q.pop_front());
                stall_run = 0;
            end
            if (!buf_bubble) begin
                if (res_q.size() == 0) flag("buf_capture");
                else chk("wb_load_data", wb_load_data, res_q.pop_front());
            end
            if (mem_req_read || mem_req_write) begin
                if (req_q.size() == 0) flag("mem_req");
                else begin
                    mrq = req_q[0];
                    chk("req_read", mem_req_read, mrq.rd);
                    chk("req_write", mem_req_write, !mrq.rd);
                    chk("req_addr", mem_req_addr, mrq.addr);
                    if (!mrq.rd) chk("req_data", mem_req_data, mrq.data);
                    if (mem_ready) void'(req_q.pop_front());
                end
            end
        end
    end

    // One memory op: r idle REQ cycles before mem_ready, v idle WAIT cycles
    // before mem_valid, same = load data arrives with mem_ready.
    task automatic run_mem(input bit rd, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] sd, input int r, input int v,
                           input bit same, input logic [DW-1:0] ld);
        bit   is_load;
        req_t e;
        is_load = rd;
        e.rd = is_load; e.addr = a; e.data = sd;
        req_q.push_back(e);
        stall_q.push_back(1 + (r + 1) + ((is_load && !same) ? (v + 1) : 0));
        if (is_load) last_load = ld;
        res_q.push_back(last_load);
        // IDLE cycle; memory handshake noise must be ignored here
        op_valid = 1'b1; memRead_in = rd; memWrite_in = wr;
        addr_in = a; store_data_in = sd;
        mem_ready = 1'($urandom); mem_valid = 1'($urandom); mem_load_data = rnd32();
        tick();
        for (int k = 0; k <= r; k++) begin
            mem_ready = (k == r);
            if (is_load && k == r) mem_valid = same;
            else mem_valid = 1'($urandom);
            mem_load_data = (is_load && k == r && same) ? ld : rnd32();
            tick();
        end
        if (is_load && !same) begin
            for (int k = 0; k <= v; k++) begin
                mem_ready = 1'($urandom);
                mem_valid = (k == v);
                mem_load_data = (k == v) ? ld : rnd32();
                tick();
            end
        end
        // DONE cycle
        mem_ready = 1'($urandom); mem_valid = 1'($urandom); mem_load_data = rnd32();
        tick();
    endtask

    task automatic run_nonmem(input bit ov, input bit rd, input bit wr);
        op_valid = ov; memRead_in = ov ? 1'b0 : rd; memWrite_in = ov ? 1'b0 : wr;
        addr_in = AW'($urandom); store_data_in = rnd32();
        mem_ready = 1'($urandom); mem_valid = 1'($urandom); mem_load_data = rnd32();
        if (ov) res_q.push_back(last_load);
        tick();
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rdat;
        int            kind;

        // Reset with a load presented: outputs must still show reset values.
        reset = 1'b0;
        op_valid = 1'b1; memRead_in = 1'b1; memWrite_in = 1'b0;
        addr_in = 20'h00040; store_data_in = 32'h0;
        mem_ready = 1'b1; mem_valid = 1'b1; mem_load_data = 32'hFFFF_FFFF;
        #3;
        chk("rst_stall", stall, 0);
        chk("rst_bubble", buf_bubble, 1);
        chk("rst_enable", buf_enable, 1);
        chk("rst_req_read", mem_req_read, 0);
        chk("rst_req_write", mem_req_write, 0);
        tick();
        chk("rst_wb", wb_load_data, 0);
        chk("rst_req_addr", mem_req_addr, 0);
        chk("rst_error", mem_error, 0);
        op_valid = 1'b0; mem_ready = 1'b0; mem_valid = 1'b0;
        #2 reset = 1'b1;
        tick();
        mon_en = 1'b1;

        // Directed cases
        run_mem(1'b1, 1'b0, 20'h00040, 32'h0, 0, 0, 1'b0, 32'hDEADBEEF);
        run_mem(1'b0, 1'b1, 20'h00100, 32'h12345678, 4, 0, 1'b0, 32'h0);
        run_mem(1'b1, 1'b0, 20'h00200, 32'h0, 0, 0, 1'b1, 32'hA5A5A5A5);
        run_nonmem(1'b1, 1'b0, 1'b0);
        run_nonmem(1'b1, 1'b0, 1'b0);
        run_nonmem(1'b1, 1'b0, 1'b0);
        run_nonmem(1'b0, 1'b1, 1'b0);
        run_nonmem(1'b0, 1'b1, 1'b1);
        run_nonmem(1'b0, 1'b0, 1'b1);
        // Read and write both set: behaves as a load
        run_mem(1'b1, 1'b1, 20'h00ABC, 32'h55AA55AA, 1, 1, 1'b0, 32'hC0FFEE01);

        // Randomized stream
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 9);
            ra   = AW'($urandom);
            rdat = rnd32();
            if (kind < 4) run_nonmem(1'($urandom), 1'($urandom), 1'($urandom));
            else run_mem(1'($urandom), 1'b1, ra, rdat, $urandom_range(0, 3),
                         $urandom_range(0, 2), 1'($urandom), rnd32());
        end
        run_mem(1'b1, 1'b0, 20'h00777, 32'h0, 1, 0, 1'b0, 32'h13579BDF);
        run_nonmem(1'b0, 1'b0, 1'b0);
        run_nonmem(1'b0, 1'b0, 1'b0);
        chk("stall_q_empty", stall_q.size(), 0);
        chk("res_q_empty", res_q.size(), 0);
        chk("req_q_empty", req_q.size(), 0);
        mon_en = 1'b0;

        // Memory that never answers
        op_valid = 1'b1; memRead_in = 1'b1; memWrite_in = 1'b0; addr_in = 20'h00300;
        mem_ready = 1'b0; mem_valid = 1'b0;
        tick();
`ifdef MEM_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            #2;
            chk("tmo_req_held", mem_req_read, 1);
            chk("tmo_no_early_error", mem_error, 0);
            tick();
        end
        #2;
        chk("tmo_error_pulse", mem_error, 1);
        chk("tmo_wb_zero", wb_load_data, 0);
        chk("tmo_req_dropped", mem_req_read, 0);
        chk("tmo_done_bubble", buf_bubble, 0);
        op_valid = 1'b0;
        tick();
        #2;
        chk("tmo_error_once", mem_error, 0);
        chk("tmo_idle_stall", stall, 0);
`else
        for (int k = 0; k < 20; k++) begin
            #2;
            chk("hang_stall", stall, 1);
            chk("hang_req", mem_req_read, 1);
            chk("hang_error", mem_error, 0);
            tick();
        end
        mem_ready = 1'b1; mem_valid = 1'b1; mem_load_data = 32'h0BAD_F00D;
        tick();
        #2;
        chk("late_done_wb", wb_load_data, 32'h0BAD_F00D);
        chk("late_done_bubble", buf_bubble, 0);
        op_valid = 1'b0; mem_ready = 1'b0; mem_valid = 1'b0;
        tick();
`endif

        // Reset while in WAIT
        op_valid = 1'b1; memRead_in = 1'b1; memWrite_in = 1'b0; addr_in = 20'h00400;
        mem_ready = 1'b0; mem_valid = 1'b0;
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        #1;
        chk("wait_stall", stall, 1);
        chk("wait_no_req", mem_req_read, 0);
        reset = 1'b0;
        #1;
        chk("rst_wait_req_read", mem_req_read, 0);
        chk("rst_wait_req_write", mem_req_write, 0);
        chk("rst_wait_stall", stall, 0);
        chk("rst_wait_error", mem_error, 0);
        chk("rst_wait_bubble", buf_bubble, 1);
        tick();
        op_valid = 1'b0;
        #2 reset = 1'b1;
        tick();
        mem_valid = 1'b1; mem_load_data = 32'h7777_7777;
        #2;
        chk("post_rst_stall", stall, 0);
        chk("post_rst_bubble", buf_bubble, 1);
        tick();
        mem_valid = 1'b0;
        #2;
        chk("late_valid_ignored", wb_load_data, 0);
        chk("post_rst_req", mem_req_read, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
